// File: rtl/operand_entry_pkg.sv
// calc_pkg: constants and types shared by the calculator datapath blocks
// (operand entry, decimal adder, display driver).
//   KEY_*       keypad codes for the non-digit keys
//   OPERAND_W   operand width in bits (must hold MAX_VAL)
//   MAX_DIGITS  decimal digits per operand
//   MAX_VAL     largest enterable operand (10^MAX_DIGITS - 1)
//   state_t     operand-entry FSM states
package calc_pkg;

  localparam logic [3:0] KEY_ADD  = 4'hA;
  localparam logic [3:0] KEY_EQ   = 4'hB;
  localparam logic [3:0] KEY_CLR  = 4'hC;
  localparam logic [3:0] KEY_BKSP = 4'hD;

  localparam int OPERAND_W  = 10;
  localparam int MAX_DIGITS = 3;
  localparam int MAX_VAL    = 999;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OUT = 2'd2
  } state_t;

endpackage

// File: rtl/operand_entry_if.sv
// operand_entry_if: bundles the keypad handshake, display outputs and the
// operand handshake towards the adder.
//   master modport: driven by the keypad decoder / adder side
//   slave  modport: used by operand_entry
// Signals:
//   key_valid/key_code/key_ready  key event handshake
//   entry_val/digit_cnt/ovf       live accumulator view for the display
//   a/b/op_valid/op_ready         operand handshake to the adder
interface operand_entry_if;
  import calc_pkg::*;

  logic                 key_valid;
  logic [3:0]           key_code;
  logic                 key_ready;
  logic [OPERAND_W-1:0] entry_val;
  logic [1:0]           digit_cnt;
  logic                 ovf;
  logic [OPERAND_W-1:0] a;
  logic [OPERAND_W-1:0] b;
  logic                 op_valid;
  logic                 op_ready;

  modport master (
    output key_valid, key_code, op_ready,
    input  key_ready, entry_val, digit_cnt, ovf, a, b, op_valid
  );

  modport slave (
    input  key_valid, key_code, op_ready,
    output key_ready, entry_val, digit_cnt, ovf, a, b, op_valid
  );

endinterface

// File: rtl/operand_entry_digit_accum.sv
// digit_accum: combinational next-value logic for the operand accumulator.
// Given the current accumulator/digit count and a key code it reports whether
// the key is handled here (digit, or backspace when enabled) and the resulting
// accumulator, count and overflow flag.
// Configuration macro: OPERAND_ENTRY_BACKSPACE_EN enables backspace (/10).
// Ports:
//   acc_i  current accumulator      cnt_i  current significant-digit count
//   key_i  accepted key code        hit_o  key handled by this block
//   acc_o  next accumulator         cnt_o  next digit count
//   ovf_o  digit dropped because the operand is already full
module digit_accum
  import calc_pkg::*;
(
  input  logic [OPERAND_W-1:0] acc_i,
  input  logic [1:0]           cnt_i,
  input  logic [3:0]           key_i,
  output logic                 hit_o,
  output logic [OPERAND_W-1:0] acc_o,
  output logic [1:0]           cnt_o,
  output logic                 ovf_o
);

  // acc*10 + d as shift-and-add; the wide intermediate is truncated back to
  // OPERAND_W, which is lossless because a full operand never reaches here.
  logic [OPERAND_W+3:0] mul10;
  logic                 unused_mul10_hi;

  assign mul10 = ({4'd0, acc_i} << 3) + ({4'd0, acc_i} << 1)
               + {{OPERAND_W{1'b0}}, key_i};
  assign unused_mul10_hi = ^mul10[OPERAND_W+3:OPERAND_W];

  always_comb begin
    hit_o = 1'b0;
    acc_o = acc_i;
    cnt_o = cnt_i;
    ovf_o = 1'b0;
    if (key_i <= 4'd9) begin
      hit_o = 1'b1;
      if (cnt_i == 2'(MAX_DIGITS)) begin
        ovf_o = 1'b1;
      end else begin
        acc_o = mul10[OPERAND_W-1:0];
        // Leading zeros leave the value at 0 and do not count as digits.
        if (!(acc_i == '0 && key_i == 4'd0)) begin
          cnt_o = cnt_i + 2'd1;
        end
      end
    end
`ifdef OPERAND_ENTRY_BACKSPACE_EN
    else if (key_i == KEY_BKSP) begin
      hit_o = 1'b1;
      if (cnt_i != 2'd0) begin
        acc_o = acc_i / OPERAND_W'(10);
        cnt_o = cnt_i - 2'd1;
      end
    end
`endif
  end

endmodule

// File: rtl/operand_entry.sv
// operand_entry: assembles decimal operands A and B from keypad events and
// hands them to the adder with a valid/ready handshake.
// Configuration macro: OPERAND_ENTRY_BACKSPACE_EN enables the BKSP key.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    operand_entry_if.slave: key handshake, display view, operands
module operand_entry
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  operand_entry_if.slave   bus
);

  state_t               state_q, state_d;
  logic [OPERAND_W-1:0] acc_q, acc_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [OPERAND_W-1:0] a_q, a_d;
  logic [OPERAND_W-1:0] b_q, b_d;
  logic                 op_valid_q, op_valid_d;
  logic                 ovf_q, ovf_d;

  logic                 key_ready;
  logic                 key_fire;
  logic                 acc_hit;
  logic [OPERAND_W-1:0] acc_next;
  logic [1:0]           cnt_next;
  logic                 acc_ovf;

  // Keys are blocked only while operands wait for the adder.
  assign key_ready = (state_q != S_OUT);
  assign key_fire  = bus.key_valid && key_ready;

  digit_accum u_accum (
    .acc_i (acc_q),
    .cnt_i (cnt_q),
    .key_i (bus.key_code),
    .hit_o (acc_hit),
    .acc_o (acc_next),
    .cnt_o (cnt_next),
    .ovf_o (acc_ovf)
  );

  // Next-state logic. Unknown codes complete the handshake but fall
  // through every branch, leaving all state untouched.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_valid_d = op_valid_q;
    ovf_d      = 1'b0;
    case (state_q)
      S_A, S_B: begin
        if (key_fire) begin
          if (acc_hit) begin
            acc_d = acc_next;
            cnt_d = cnt_next;
            ovf_d = acc_ovf;
          end else if (bus.key_code == KEY_CLR) begin
            acc_d   = '0;
            cnt_d   = '0;
            a_d     = '0;
            b_d     = '0;
            state_d = S_A;
          end else if (bus.key_code == KEY_ADD && state_q == S_A) begin
            a_d     = acc_q;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_B;
          end else if (bus.key_code == KEY_EQ && state_q == S_B) begin
            b_d        = acc_q;
            op_valid_d = 1'b1;
            state_d    = S_OUT;
          end
        end
      end
      S_OUT: begin
        // a/b are kept after the handshake so the display can show them.
        if (op_valid_q && bus.op_ready) begin
          op_valid_d = 1'b0;
          acc_d      = '0;
          cnt_d      = '0;
          state_d    = S_A;
        end
      end
      default: begin
        state_d = S_A;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_A;
      acc_q      <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_valid_q <= op_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.key_ready = key_ready;
  assign bus.entry_val = acc_q;
  assign bus.digit_cnt = cnt_q;
  assign bus.ovf       = ovf_q;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.op_valid  = op_valid_q;

endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry: self-checking bench for operand_entry. A behavioural
// model holds the operands as plain integers and applies the keypad rules
// directly; directed scenarios are followed by a randomized key stream.
// Honours OPERAND_ENTRY_BACKSPACE_EN when defined for the build.
module tb_operand_entry;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  // Behavioural model
  int mAcc, mCnt, mA, mB;
  bit mOut, mOnB, mOvf;

  operand_entry_if bus();

  operand_entry dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Overall time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_clear();
    mAcc = 0; mCnt = 0; mA = 0; mB = 0;
    mOut = 0; mOnB = 0; mOvf = 0;
  endtask

  // Apply one accepted key to the model using the keypad rules.
  task automatic model_key(input logic [3:0] code);
    if (code <= 4'd9) begin
      if (mCnt == MAX_DIGITS) mOvf = 1;
      else begin
        if (!(mAcc == 0 && code == 0)) mCnt++;
        mAcc = mAcc * 10 + int'(code);
      end
    end else if (code == KEY_CLR) begin
      mAcc = 0; mCnt = 0; mA = 0; mB = 0; mOnB = 0;
    end else if (code == KEY_ADD && !mOnB) begin
      mA = mAcc; mAcc = 0; mCnt = 0; mOnB = 1;
    end else if (code == KEY_EQ && mOnB) begin
      mB = mAcc; mOut = 1;
    end
`ifdef OPERAND_ENTRY_BACKSPACE_EN
    else if (code == KEY_BKSP && mCnt > 0) begin
      mAcc = mAcc / 10; mCnt--;
    end
`endif
  endtask

  // One clock cycle of stimulus; the model advances with the edge and the
  // caller samples 1 time unit after it.
  task automatic step(input bit kv, input logic [3:0] code, input bit rdy);
    @(negedge clk);
    bus.key_valid = kv;
    bus.key_code  = code;
    bus.op_ready  = rdy;
    @(posedge clk);
    mOvf = 0;
    if (mOut) begin
      if (rdy) begin mOut = 0; mAcc = 0; mCnt = 0; mOnB = 0; end
    end else if (kv) begin
      model_key(code);
    end
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    step(1'b1, code, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.op_ready  = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    compared++; if (bus.entry_val !== '0) begin mismatched++; $display("[TB] FAIL reset_entry_val: got %0d want 0", bus.entry_val); end
    compared++; if (bus.digit_cnt !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_digit_cnt: got %0d want 0", bus.digit_cnt); end
    compared++; if (bus.op_valid !== 1'b0 || bus.ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_flags: op_valid=%b ovf=%b want 0/0", bus.op_valid, bus.ovf); end
    compared++; if (bus.a !== '0 || bus.b !== '0) begin mismatched++; $display("[TB] FAIL reset_ab: a=%0d b=%0d want 0/0", bus.a, bus.b); end
    compared++; if (bus.key_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_key_ready: got %b want 1", bus.key_ready); end
  endtask

  task automatic test_basic();
    press(4'd1); press(4'd2); press(4'd3); press(KEY_ADD);
    press(4'd4); press(4'd5); press(KEY_EQ);
    compared++; if (bus.op_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_op_valid: got %b want 1", bus.op_valid); end
    compared++; if (bus.a !== 10'd123 || bus.b !== 10'd45) begin mismatched++; $display("[TB] FAIL basic_ab: a=%0d b=%0d want 123/45", bus.a, bus.b); end
    compared++; if (bus.key_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_key_ready: got %b want 0", bus.key_ready); end
    step(1'b0, 4'h0, 1'b1);
    compared++; if (bus.op_valid !== 1'b0 || bus.key_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_consume: op_valid=%b key_ready=%b want 0/1", bus.op_valid, bus.key_ready); end
    compared++; if (bus.entry_val !== '0 || bus.a !== 10'd123) begin mismatched++; $display("[TB] FAIL basic_after: entry_val=%0d a=%0d want 0/123", bus.entry_val, bus.a); end
  endtask

  task automatic test_overflow();
    press(4'd9); press(4'd9); press(4'd9);
    compared++; if (bus.entry_val !== 10'd999 || bus.digit_cnt !== 2'd3 || bus.ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_full: val=%0d cnt=%0d ovf=%b want 999/3/0", bus.entry_val, bus.digit_cnt, bus.ovf); end
    press(4'd9);
    compared++; if (bus.ovf !== 1'b1 || bus.entry_val !== 10'd999) begin mismatched++; $display("[TB] FAIL ovf_pulse: ovf=%b val=%0d want 1/999", bus.ovf, bus.entry_val); end
    step(1'b0, 4'h0, 1'b0);
    compared++; if (bus.ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_one_cycle: got %b want 0", bus.ovf); end
    press(KEY_ADD); press(4'd9); press(4'd9); press(4'd9); press(KEY_EQ);
    compared++; if (bus.a !== 10'd999 || bus.b !== 10'd999 || bus.op_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_ab: a=%0d b=%0d v=%b want 999/999/1", bus.a, bus.b, bus.op_valid); end
    step(1'b0, 4'h0, 1'b1);
  endtask

  task automatic test_leading_zero();
    press(4'd0); press(4'd0); press(4'd7);
    compared++; if (bus.digit_cnt !== 2'd1 || bus.entry_val !== 10'd7) begin mismatched++; $display("[TB] FAIL lz_value: cnt=%0d val=%0d want 1/7", bus.digit_cnt, bus.entry_val); end
    press(KEY_ADD); press(KEY_EQ);
    compared++; if (bus.a !== 10'd7 || bus.b !== 10'd0 || bus.op_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL lz_ab: a=%0d b=%0d v=%b want 7/0/1", bus.a, bus.b, bus.op_valid); end
    step(1'b0, 4'h0, 1'b1);
  endtask

  task automatic test_back_to_back_stall();
    press(4'd1); press(KEY_ADD); press(4'd2); press(KEY_EQ);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'd5, 1'b0);
      compared++; if (bus.key_ready !== 1'b0 || bus.op_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_hs[%0d]: key_ready=%b op_valid=%b want 0/1", i, bus.key_ready, bus.op_valid); end
      compared++; if (bus.a !== 10'd1 || bus.b !== 10'd2 || bus.entry_val !== 10'd2) begin mismatched++; $display("[TB] FAIL stall_data[%0d]: a=%0d b=%0d val=%0d want 1/2/2", i, bus.a, bus.b, bus.entry_val); end
    end
    step(1'b0, 4'h0, 1'b1);
    compared++; if (bus.op_valid !== 1'b0 || bus.entry_val !== '0) begin mismatched++; $display("[TB] FAIL stall_release: v=%b val=%0d want 0/0", bus.op_valid, bus.entry_val); end
  endtask

  task automatic test_clear();
    press(4'd4); press(4'd2); press(KEY_ADD); press(4'd6); press(KEY_CLR);
    compared++; if (bus.a !== '0 || bus.b !== '0 || bus.entry_val !== '0) begin mismatched++; $display("[TB] FAIL clr_values: a=%0d b=%0d val=%0d want 0/0/0", bus.a, bus.b, bus.entry_val); end
    press(KEY_EQ);  // back in S_A, so EQ must be ignored
    compared++; if (bus.op_valid !== 1'b0 || bus.key_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL clr_state: v=%b key_ready=%b want 0/1", bus.op_valid, bus.key_ready); end
    press(4'd3); press(KEY_ADD); press(4'd8); press(KEY_EQ);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    compared++; if (bus.op_valid !== 1'b0 || bus.a !== '0 || bus.key_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL async_reset: v=%b a=%0d key_ready=%b want 0/0/1", bus.op_valid, bus.a, bus.key_ready); end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_backspace();
    press(4'd1); press(4'd2); press(4'd3); press(KEY_BKSP);
`ifdef OPERAND_ENTRY_BACKSPACE_EN
    compared++; if (bus.entry_val !== 10'd12 || bus.digit_cnt !== 2'd2) begin mismatched++; $display("[TB] FAIL bksp_one: val=%0d cnt=%0d want 12/2", bus.entry_val, bus.digit_cnt); end
    press(KEY_BKSP); press(KEY_BKSP); press(KEY_BKSP);
    compared++; if (bus.entry_val !== '0 || bus.digit_cnt !== 2'd0) begin mismatched++; $display("[TB] FAIL bksp_empty: val=%0d cnt=%0d want 0/0", bus.entry_val, bus.digit_cnt); end
`else
    compared++; if (bus.entry_val !== 10'd123 || bus.digit_cnt !== 2'd3) begin mismatched++; $display("[TB] FAIL bksp_ignored: val=%0d cnt=%0d want 123/3", bus.entry_val, bus.digit_cnt); end
`endif
    press(4'hE); press(4'hF);
    compared++; if (bus.entry_val !== 10'(mAcc) || bus.key_ready !== 1'b1 || bus.op_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL undef_codes: val=%0d want %0d ready=%b v=%b", bus.entry_val, mAcc, bus.key_ready, bus.op_valid); end
    press(KEY_CLR);
  endtask

  task automatic test_random();
    logic [3:0] code;
    bit kv, rdy;
    for (int i = 0; i < 600; i++) begin
      kv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) < 7) code = 4'($urandom_range(0, 9));
      else code = 4'($urandom_range(10, 15));
      step(kv, code, rdy);
      compared++; if (bus.entry_val !== 10'(mAcc) || bus.digit_cnt !== 2'(mCnt)) begin mismatched++; $display("[TB] FAIL rand_acc[%0d]: val=%0d cnt=%0d want %0d/%0d", i, bus.entry_val, bus.digit_cnt, mAcc, mCnt); end
      compared++; if (bus.a !== 10'(mA) || bus.b !== 10'(mB)) begin mismatched++; $display("[TB] FAIL rand_ab[%0d]: a=%0d b=%0d want %0d/%0d", i, bus.a, bus.b, mA, mB); end
      compared++; if (bus.op_valid !== mOut || bus.key_ready !== !mOut || bus.ovf !== mOvf) begin mismatched++; $display("[TB] FAIL rand_flags[%0d]: v=%b rdy=%b ovf=%b want %b/%b/%b", i, bus.op_valid, bus.key_ready, bus.ovf, mOut, !mOut, mOvf); end
    end
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.op_ready  = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_overflow();
    test_leading_zero();
    test_back_to_back_stall();
    test_clear();
    test_backspace();
    do_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
